fault_campaign_ctrl: RTL and testbench



---
 rtl/fault_campaign_ctrl.sv | 172 +++++++++++++++++
 tb/tb_fault_campaign_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fault_campaign_ctrl.sv
// Stuck-at fault campaign controller for a 4-bit adder: one golden pass, then
// one exhaustive 512-vector pass per (gate, stuck value). Optional trace port under FAULT_TRACE_EN.
module fault_campaign_ctrl #(
  parameter int NG        = 128,
  parameter int NUM_GATES = 16,
  parameter int GID_BASE  = 0,
  parameter int ERR_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  output logic [3:0]             X,
  output logic [3:0]             Y,
  output logic                   Cin,
  output logic [NG-1:0]          fault_en_bus,
  output logic                   fault_val,
  input  logic [3:0]             dut_S,
  input  logic                   dut_Cout,
  output logic                   busy,
  output logic                   done,
  output logic [ERR_W-1:0]       err_count,
  output logic [9:0]             gold_err,
  output logic [2*NUM_GATES-1:0] detected
`ifdef FAULT_TRACE_EN
  ,
  output logic                   trace_valid,
  output logic [5:0]             trace_pass,
  output logic [13:0]            trace_data
`endif
);

  localparam int NPASS = 1 + 2*NUM_GATES;
  localparam int PW    = $clog2(NPASS + 1);
  localparam int DW    = 2*NUM_GATES;

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_SAMPLE, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [8:0]        vec_q, vec_d;
  logic [PW-1:0]     pass_q, pass_d;
  logic [NG-1:0]     fen_q, fen_d;
  logic              fv_q, fv_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [9:0]        gold_q, gold_d;
  logic [DW-1:0]     det_q, det_d;

  logic [4:0]        gold_sum;
  logic              mismatch;
  logic              hit;
  logic [PW-1:0]     gidx;

  // Stimulus comes straight from the vector register, so the reference sum does too.
  assign gold_sum = {1'b0, vec_q[3:0]} + {1'b0, vec_q[7:4]} + {4'b0, vec_q[8]};
  assign mismatch = ({dut_Cout, dut_S} != gold_sum);
  assign hit      = (state_q == S_SAMPLE) && !abort && mismatch;
  assign gidx     = pass_q >> 1;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    pass_d  = pass_q;
    fen_d   = fen_q;
    fv_d    = fv_q;
    err_d   = err_q;
    gold_d  = gold_q;
    det_d   = det_q;
    if (abort) begin
      state_d = S_IDLE;
      fen_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_APPLY;
            vec_d   = '0;
            pass_d  = '0;
            fen_d   = '0;
            fv_d    = 1'b0;
            err_d   = '0;
            gold_d  = '0;
            det_d   = '0;
          end
        end
        S_APPLY: state_d = S_SAMPLE;
        S_SAMPLE: begin
          if (hit) begin
            if (pass_q == '0) begin
              gold_d = gold_q + 10'd1;
            end else begin
              if (err_q != '1) err_d = err_q + ERR_W'(1);
              det_d = det_q | (DW'(1) << (pass_q - PW'(1)));
            end
          end
          vec_d   = vec_q + 9'd1;
          state_d = S_APPLY;
          if (vec_q == 9'd511) begin
            if (pass_q == PW'(NPASS - 1)) begin
              state_d = S_DONE;
              fen_d   = '0;
              fv_d    = 1'b0;
            end else begin
              // Next pass p = pass_q+1 targets gate (p-1)>>1 with stuck value (p-1)&1.
              pass_d = pass_q + PW'(1);
              fen_d  = (NG'(1) << GID_BASE) << gidx;
              fv_d   = pass_q[0];
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      pass_q  <= '0;
      fen_q   <= '0;
      fv_q    <= 1'b0;
      err_q   <= '0;
      gold_q  <= '0;
      det_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      pass_q  <= pass_d;
      fen_q   <= fen_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
      gold_q  <= gold_d;
      det_q   <= det_d;
    end
  end

  assign X            = vec_q[3:0];
  assign Y            = vec_q[7:4];
  assign Cin          = vec_q[8];
  assign fault_en_bus = fen_q;
  assign fault_val    = fv_q;
  assign busy         = (state_q == S_APPLY) || (state_q == S_SAMPLE);
  assign done         = (state_q == S_DONE);
  assign err_count    = err_q;
  assign gold_err     = gold_q;
  assign detected     = det_q;

`ifdef FAULT_TRACE_EN
  logic        tv_q;
  logic [5:0]  tp_q;
  logic [13:0] td_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tv_q <= 1'b0;
      tp_q <= '0;
      td_q <= '0;
    end else begin
      tv_q <= hit;
      if (hit) begin
        tp_q <= 6'(pass_q);
        td_q <= {vec_q, dut_Cout, dut_S};
      end
    end
  end

  assign trace_valid = tv_q;
  assign trace_pass  = tp_q;
  assign trace_data  = td_q;
`endif

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Directed bench for fault_campaign_ctrl: two controllers (ERR_W 16 and 8) each
// drive a behavioural faultable 4-bit adder; probe table plus abort/reset sequences.
module tb_fault_campaign_ctrl;
  localparam int NG     = 128;
  localparam int NGATES = 4;
  localparam int GBASE  = 2;
  localparam int TOTAL  = 1024*(1 + 2*NGATES);

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, abort = 1'b0;
  bit   ideal = 1'b1, gold_bug = 1'b0;

  always #5 clk = ~clk;

  logic [3:0] x16, y16, s16, x8, y8, s8;
  logic cin16, fv16, co16, busy16, done16, cin8, fv8, co8, busy8, done8;
  logic [NG-1:0] fen16, fen8;
  logic [15:0] err16;
  logic [7:0]  err8;
  logic [9:0]  gold16, gold8;
  logic [2*NGATES-1:0] det16, det8;

  int n_tests = 0, n_fail = 0;

  // Fault IDs per bit i: 4i = sum, 4i+1 = propagate, 4i+2 = generate, 4i+3 = carry-out.
  function automatic logic [4:0] cla(input logic [3:0] x, input logic [3:0] y,
                                     input logic ci, input int fid, input logic fv);
    logic c, p, g, s;
    logic [3:0] sm;
    c = ci;
    sm = '0;
    for (int i = 0; i < 4; i++) begin
      p = x[i] ^ y[i];
      g = x[i] & y[i];
      if (fid == 4*i+1) p = fv;
      if (fid == 4*i+2) g = fv;
      s = p ^ c;
      if (fid == 4*i) s = fv;
      c = g | (p & c);
      if (fid == 4*i+3) c = fv;
      sm[i] = s;
    end
    return {c, sm};
  endfunction

  function automatic int fidx(input logic [NG-1:0] f);
    for (int i = 0; i < NG; i++) if (f[i]) return i;
    return -1;
  endfunction

  function automatic logic [4:0] dut_model(input logic [3:0] x, input logic [3:0] y,
                                           input logic ci, input logic [NG-1:0] fen,
                                           input logic fv, input bit idl, input bit gb);
    logic [4:0] r;
    r = {1'b0, x} + {1'b0, y} + {4'b0, ci};
    if (fen != '0) begin
      if (!idl) r = cla(x, y, ci, fidx(fen), fv);
    end else if (gb && x == y) begin
      r[0] = ~r[0];
    end
    return r;
  endfunction

  function automatic int ref_total();
    int t;
    logic [8:0] vv;
    logic [4:0] g;
    t = 0;
    for (int p = 1; p <= 2*NGATES; p++)
      for (int v = 0; v < 512; v++) begin
        vv = 9'(v);
        g  = {1'b0, vv[3:0]} + {1'b0, vv[7:4]} + {4'b0, vv[8]};
        if (cla(vv[3:0], vv[7:4], vv[8], GBASE + (p-1)/2, 1'((p-1)%2)) != g) t++;
      end
    return t;
  endfunction

  assign {co16, s16} = dut_model(x16, y16, cin16, fen16, fv16, ideal, gold_bug);
  assign {co8,  s8}  = dut_model(x8,  y8,  cin8,  fen8,  fv8,  ideal, gold_bug);

  fault_campaign_ctrl #(.NG(NG), .NUM_GATES(NGATES), .GID_BASE(GBASE), .ERR_W(16)) u16 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .X(x16), .Y(y16), .Cin(cin16), .fault_en_bus(fen16), .fault_val(fv16),
    .dut_S(s16), .dut_Cout(co16), .busy(busy16), .done(done16),
    .err_count(err16), .gold_err(gold16), .detected(det16));

  fault_campaign_ctrl #(.NG(NG), .NUM_GATES(NGATES), .GID_BASE(GBASE), .ERR_W(8)) u8 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .X(x8), .Y(y8), .Cin(cin8), .fault_en_bus(fen8), .fault_val(fv8),
    .dut_S(s8), .dut_Cout(co8), .busy(busy8), .done(done8),
    .err_count(err8), .gold_err(gold8), .detected(det8));

  task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Leaves the bench at the falling edge right after the edge that sampled start (k = 0).
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_u16"}, {x16, y16, cin16, fen16, fv16, busy16, done16, err16, gold16, det16}, '0);
    chk({nm, "_u8"},  {x8,  y8,  cin8,  fen8,  fv8,  busy8,  done8,  err8,  gold8,  det8},  '0);
  endtask

  task automatic chk_final(input string nm, input int tot, input int gexp);
    chk({nm, "_err16"}, err16, 16'(tot));
    chk({nm, "_err8_sat"}, err8, (tot > 255) ? 8'hFF : 8'(tot));
    chk({nm, "_gold"}, {gold16, gold8}, {10'(gexp), 10'(gexp)});
    chk({nm, "_det"}, {det16, det8}, {8'hFF, 8'hFF});
  endtask

  typedef struct {
    int k; logic [3:0] x, y; logic cin; int fi; logic fv, busy, done;
  } probe_t;
  probe_t tbl[12];

  initial begin
    int tot;
    logic [NG-1:0] fe;

    tbl[0]  = '{0,    4'h0, 4'h0, 1'b0, -1, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1,    4'h0, 4'h0, 1'b0, -1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{2,    4'h1, 4'h0, 1'b0, -1, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{842,  4'h5, 4'hA, 1'b1, -1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1023, 4'hF, 4'hF, 1'b1, -1, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1024, 4'h0, 4'h0, 1'b0,  2, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{2048, 4'h0, 4'h0, 1'b0,  2, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{3192, 4'hC, 4'h3, 1'b0,  3, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{8192, 4'h0, 4'h0, 1'b0,  5, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{9215, 4'hF, 4'hF, 1'b1,  5, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{9216, 4'h0, 4'h0, 1'b0, -1, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{9300, 4'h0, 4'h0, 1'b0, -1, 1'b0, 1'b0, 1'b1};

    tot = ref_total();

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Run 1: ideal adder, timing probes along the whole campaign.
    ideal = 1'b1; gold_bug = 1'b0;
    pulse_start();
    for (int k = 0; k <= 9300; k++) begin
      foreach (tbl[i]) if (tbl[i].k == k) begin
        fe = (tbl[i].fi < 0) ? '0 : (NG'(1) << tbl[i].fi);
        chk($sformatf("probe_k%0d", k), {x16, y16, cin16, fen16, fv16, busy16, done16},
            {tbl[i].x, tbl[i].y, tbl[i].cin, fe, tbl[i].fv, tbl[i].busy, tbl[i].done});
      end
      @(negedge clk);
    end
    chk("ideal_counters", {err16, gold16, det16, err8, gold8, det8}, '0);

    // Run 2: abort (together with start) at edge 1000, then a full restart.
    ideal = 1'b0; gold_bug = 1'b1;
    pulse_start();
    repeat (999) @(negedge clk);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("abort_outputs", {busy16, done16, fen16, busy8, done8, fen8}, '0);
    chk("abort_held", {gold16, err16}, {10'd31, 16'd0});
    @(negedge clk);
    chk("abort_idle", {busy16, done16, gold16}, {1'b0, 1'b0, 10'd31});
    pulse_start();
    chk("restart_clear", {err16, gold16, det16, busy16}, {16'd0, 10'd0, 8'd0, 1'b1});
    repeat (TOTAL - 1) @(negedge clk);
    chk("restart_not_done", {done16, busy16}, 2'b01);
    @(negedge clk);
    chk("restart_done", {done16, busy16, done8}, 3'b101);
    chk_final("run2", tot, 32);

    // Run 3: start during busy is ignored; reset mid-campaign; restart from IDLE.
    gold_bug = 1'b0;
    pulse_start();
    repeat (500) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("busy_start_ignored", {x16, y16, cin16, busy16}, {4'hB, 4'hF, 1'b0, 1'b1});
    repeat (2498) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk_zero("midrun_reset");
    rst = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", {busy16, done16, err16}, '0);
    pulse_start();
    repeat (TOTAL - 1) @(negedge clk);
    chk("run3_not_done", done16, 1'b0);
    @(negedge clk);
    chk("run3_done", {done16, done8}, 2'b11);
    chk_final("run3", tot, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
